// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressable data memory responder with fixed response latency
module dmem_responder #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = "data.hex"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  localparam logic [3:0] LAT   = 4'(LATENCY);
  localparam int         DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  active_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q, we_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept, req_err, enter_resp;
  logic [ADDR_WIDTH-1:0] wr_addr, ld_addr;
  logic [1:0]            ld_size;
  logic                  ld_uns, ld_we, ld_err;
  logic [7:0]            b0, b1, b2, b3;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];
  assign accept         = req_valid_i & req_ready_o;
  assign wr_addr        = req_addr_i[ADDR_WIDTH-1:0];

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = |req_addr_i[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = 4'd1;
        state_d = (LAT == 4'd1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == LAT) state_d = S_RESP;
      end
      S_RESP: if (rsp_ready_i) begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o = active_q;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

  // With LATENCY=1 the read happens on the accept edge, so the live request fields are used in IDLE.
  assign ld_addr    = (state_q == S_IDLE) ? wr_addr        : addr_q;
  assign ld_size    = (state_q == S_IDLE) ? req_size_i     : size_q;
  assign ld_uns     = (state_q == S_IDLE) ? req_unsigned_i : uns_q;
  assign ld_we      = (state_q == S_IDLE) ? req_we_i       : we_q;
  assign ld_err     = (state_q == S_IDLE) ? req_err        : err_q;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  assign b0 = mem_q[ld_addr];
  assign b1 = mem_q[ld_addr + ADDR_WIDTH'(1)];
  assign b2 = mem_q[ld_addr + ADDR_WIDTH'(2)];
  assign b3 = mem_q[ld_addr + ADDR_WIDTH'(3)];

  always_comb begin
    case (ld_size)
      2'b00:   ld_data = {{(DATA_WIDTH-8){~ld_uns & b0[7]}}, b0};
      2'b01:   ld_data = {{(DATA_WIDTH-16){~ld_uns & b1[7]}}, b1, b0};
      default: ld_data = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= wr_addr;
        size_q <= req_size_i;
        uns_q  <= req_unsigned_i;
        we_q   <= req_we_i;
        err_q  <= req_err;
      end
      if (enter_resp) rdata_q <= (ld_err | ld_we) ? '0 : ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we_i && !req_err) begin
      mem_q[wr_addr] <= req_wdata_i[7:0];
      if (req_size_i != 2'b00) mem_q[wr_addr + ADDR_WIDTH'(1)] <= req_wdata_i[15:8];
      if (req_size_i == 2'b10) begin
        mem_q[wr_addr + ADDR_WIDTH'(2)] <= req_wdata_i[23:16];
        mem_q[wr_addr + ADDR_WIDTH'(3)] <= req_wdata_i[31:24];
      end
    end
  end

  localparam string unused_init_file = INIT_FILE;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_mem [0:4095];

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flat byte array, little-endian, sign handled arithmetically.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int     n;
    int     a;
    longint v;
    n  = 1 << sz;
    a  = int'(addr % 4096);
    er = (sz == 2'd3) || ((addr % n) != 0);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[(a + i) % 4096] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 4096]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        rd = 32'(v);
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_req(input string name, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    chk({name, " ready_before"}, {31'd0, req_ready_o}, 32'd1);
    do_req(we, sz, uns, addr, wd, rd, er, lat);
    chk({name, " latency"}, 32'(lat), 32'(LAT));
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " err"}, {31'd0, er}, {31'd0, exp_err});
    chk({name, " valid_after"}, {31'd0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_rd, tmp, addr, wd;
    logic        exp_err, we, uns;
    logic [1:0]  sz;
    logic [11:0] base;
    int          lat;

    vecs[0]  = '{"st_w_10",      1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"ld_w_10",      1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,       32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"ld_b_13_s",    1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,       32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{"ld_b_13_u",    1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,       32'h000000DE, 1'b0};
    vecs[4]  = '{"ld_h_10_s",    1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,       32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{"ld_h_12_u",    1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,       32'h0000DEAD, 1'b0};
    vecs[6]  = '{"st_b_11",      1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'hAAAA_BB55, 32'h0,      1'b0};
    vecs[7]  = '{"ld_w_10_part", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,       32'hDEAD55EF, 1'b0};
    vecs[8]  = '{"ld_h_13_mis",  1'b0, 2'd1, 1'b0, 32'h0000_0013, 32'h0,       32'h0,        1'b1};
    vecs[9]  = '{"st_w_12_mis",  1'b1, 2'd2, 1'b0, 32'h0000_0012, 32'h12345678, 32'h0,       1'b1};
    vecs[10] = '{"ld_w_10_keep", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,       32'hDEAD55EF, 1'b1 & 1'b0};
    vecs[11] = '{"ld_sz3",       1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,       32'h0,        1'b1};
    vecs[12] = '{"st_h_wrap",    1'b1, 2'd1, 1'b0, 32'h0001_2FFE, 32'h1234A5A5, 32'h0,       1'b0};
    vecs[13] = '{"ld_h_ffe_s",   1'b0, 2'd1, 1'b0, 32'h0000_7FFE, 32'h0,       32'hFFFFA5A5, 1'b0};
    vecs[14] = '{"ld_b_fff_u",   1'b0, 2'd0, 1'b1, 32'h0000_0FFF, 32'h0,       32'h000000A5, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst rdata", rsp_rdata_o, 32'd0);
    chk("rst err", {31'd0, rsp_err_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst ready", {31'd0, req_ready_o}, 32'd1);

    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);

    // Response backpressure with an ignored request presented meanwhile
    req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 32'(lat), 32'(LAT));
    req_we = 1'b1; req_wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp rdata", rsp_rdata_o, 32'hDEAD55EF);
      chk("bp ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp ready rise", {31'd0, req_ready_o}, 32'd1);
    chk("bp valid drop", {31'd0, rsp_valid_o}, 32'd0);
    run_req("bp ignored store", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

    // Asynchronous reset while waiting
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("mid-rst ready", {31'd0, req_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid-rst no rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid-rst ready after", {31'd0, req_ready_o}, 32'd1);
    chk("mid-rst no rsp after", {31'd0, rsp_valid_o}, 32'd0);
    run_req("mid-rst store kept", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Randomised traffic against the reference, over two fully written regions
    for (int r = 0; r < 2; r++)
      for (int off = 0; off < 256; off += 4) begin
        addr = {20'd0, (r == 0) ? 12'h000 : 12'hF00} + 32'(off);
        wd   = $urandom;
        model(1'b1, 2'd2, 1'b0, addr, wd, exp_rd, exp_err);
        run_req("preload", 1'b1, 2'd2, 1'b0, addr, wd, exp_rd, exp_err);
      end
    for (int i = 0; i < 300; i++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      base = ($urandom_range(0, 1) == 1) ? 12'hF00 : 12'h000;
      tmp  = $urandom;
      addr = {tmp[31:12], base | 12'($urandom_range(0, 255))};
      wd   = $urandom;
      model(we, sz, uns, addr, wd, exp_rd, exp_err);
      run_req("rand", we, sz, uns, addr, wd, exp_rd, exp_err);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's memory stage. It is the target end of the load/store request path that the datapath drives with ALUResultM, WriteDataM and MemWriteM.
- Accepts one request at a time over a valid/ready handshake and holds a byte-addressable array.
- Performs byte, half or word stores, and sign- or zero-extended loads.
- Returns a response after a fixed, parameterised latency. The response uses its own valid/ready handshake, so the hazard logic can stall the pipeline on ready/valid.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 12, byte-address bits used; the array holds 2^ADDR_WIDTH bytes.
- LATENCY, 2, cycles from the accept edge to rsp_valid_o rising; legal range 1..15.
- INIT_FILE, "data.hex", hex image loaded when the optional feature is on.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned_i  in  1  load zero-extends when 1 (LBU/LHU)
- req_addr_i  in  DATA_WIDTH  byte address; only the low ADDR_WIDTH bits are used
- req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes the response
- rsp_rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors
- rsp_err_o  out  1  misaligned access or illegal size

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Values while rst_n is low: state = IDLE, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, latency counter = 0.
- Values after reset deassertion: req_ready_o = 1 from the first clk edge onward.
- Memory array contents are not reset.
- FSM states:
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o at an edge, the request fields are registered and the FSM goes to WAIT with counter = 1.
  - WAIT: req_ready_o = 0. The counter increments each edge. When the counter equals LATENCY, the FSM goes to RESP. If LATENCY = 1, the accept edge goes directly to RESP.
  - RESP: rsp_valid_o = 1 and rsp_rdata_o/rsp_err_o are stable. On rsp_ready_i at an edge, the FSM goes to IDLE. There is no fall-through: a new request cannot be accepted in the same cycle a response completes.
- Resulting timing: rsp_valid_o rises exactly LATENCY edges after the accept edge, and is held until rsp_ready_i is seen.
- Alignment:
  - Half accesses require addr[0] = 0.
  - Word accesses require addr[1:0] = 0.
  - Size 11 is always an error.
  - An error sets rsp_err_o = 1 and rsp_rdata_o = 0. Errored stores do not modify the array.
- Stores:
  - Committed on the accept edge.
  - Byte order is little-endian: wdata[7:0] goes to addr, wdata[15:8] to addr+1, and so on.
  - Only the bytes selected by size are written.
  - rsp_rdata_o = 0 in the store response.
- Loads:
  - The array is read using the registered address when the FSM enters RESP.
  - Byte and half results are sign-extended from bit 7 / bit 15 unless req_unsigned_i was 1, in which case they are zero-extended.
- Address wrap: bits above ADDR_WIDTH are ignored, so an access near the top of the array aliases to its low-bit address.
- Ordering: a load immediately following a store to the same address returns the new data, because the store commits before the next accept.
- Ignored inputs: req_* are ignored while req_ready_o = 0. rsp_ready_i is ignored outside RESP.
- Reset mid-operation: the outstanding response is dropped and the FSM returns to IDLE. A store already accepted remains committed.

Optional Feature:
- Macro: DMEM_INIT_EN.
- When defined: the array is loaded from INIT_FILE with $readmemh at elaboration, one byte per line, starting at address 0.
- When not defined: array contents are X until written, and INIT_FILE is unused.

Test Plan:
- Word store then load: store word 0xDEADBEEF at 0x010, then load word at 0x010. Required: rsp_valid_o high exactly 2 edges after each accept; load rdata = 0xDEADBEEF, err = 0.
- Byte/half extension: after the store above, load byte at 0x013 signed gives 0xFFFFFFDE; unsigned gives 0x000000DE. Load half at 0x010 signed gives 0xFFFFBEEF.
- Partial store: store byte 0x55 at 0x011, then load word at 0x010. Required: 0xDEAD55EF.
- Misaligned access: load half at 0x013 gives err = 1, rdata = 0. A store word at 0x012 gives err = 1, and a following load word at 0x010 is unchanged.
- Response backpressure: hold rsp_ready_i = 0 for 5 cycles. Required: rsp_valid_o and rsp_rdata_o stay stable, req_ready_o stays 0 throughout, and req_ready_o rises on the edge after rsp_ready_i goes high.
- Reset mid-operation: assert rst_n = 0 during WAIT, asynchronously. Required: rsp_valid_o = 0 and req_ready_o = 0 immediately; no response ever appears; after release, req_ready_o = 1 on the next edge.
